// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard bundle: ID/EX/MEM hazard sources in,
// per-stage enable/flush controls and status out.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd_addr;
  logic             ex_regWEn;
  logic [1:0]       ex_WBSel;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout_err;

  modport slave (
    input  id_rs1_addr, id_rs2_addr,
    input  id_rs1_used, id_rs2_used,
    input  ex_rd_addr, ex_regWEn,
    input  ex_WBSel, ex_br_taken,
    input  mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush,
    output id_ex_en, id_ex_flush,
    output ex_mem_en, mem_wb_en,
    output state, stall_cnt, flush_cnt,
    output mem_timeout_err
  );

  modport master (
    output id_rs1_addr, id_rs2_addr,
    output id_rs1_used, id_rs2_used,
    output ex_rd_addr, ex_regWEn,
    output ex_WBSel, ex_br_taken,
    output mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush,
    input  id_ex_en, id_ex_flush,
    input  ex_mem_en, mem_wb_en,
    input  state, stall_cnt, flush_cnt,
    input  mem_timeout_err
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer: load-use bubbles, memory waits,
// EX redirects, plus stall/flush counters and timeout flag.
module hazard_stall_ctrl #(
  parameter logic [1:0] LOAD_WBSEL        = 2'b00,
  parameter int         LOAD_STALL_CYCLES = 1,
  parameter int         MEM_TIMEOUT       = 16,
  parameter int         CNT_W             = 32
) (
  input logic                clk,
  input logic                reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WT_W-1:0] TO_MAX =
    WT_W'(MEM_TIMEOUT);
  localparam logic [1:0] REM_INIT =
    2'(LOAD_STALL_CYCLES - 1);

  // ctrl bits: pc, if_id_en, if_id_fl, id_ex_en,
  // id_ex_fl, ex_mem_en, mem_wb_en
  localparam logic [6:0] C_OFF   = 7'b000_0000;
  localparam logic [6:0] C_FLUSH = 7'b111_1111;
  localparam logic [6:0] C_STALL = 7'b000_1111;
  localparam logic [6:0] C_RUN   = 7'b110_1011;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_rem;
  logic [WT_W-1:0]  r_wait;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_err;

  logic       w_mem_stall;
  logic       w_hit1;
  logic       w_hit2;
  logic       w_load_use;
  logic       w_sel_rst;
  logic       w_sel_mem;
  logic       w_sel_br;
  logic       w_sel_stall;
  logic [6:0] w_ctrl;

  assign w_mem_stall = bus.mem_req & ~bus.mem_ready;

  assign w_hit1 = bus.id_rs1_used &
    (bus.id_rs1_addr == bus.ex_rd_addr);
  assign w_hit2 = bus.id_rs2_used &
    (bus.id_rs2_addr == bus.ex_rd_addr);

  assign w_load_use = bus.ex_regWEn &
    (bus.ex_WBSel == LOAD_WBSEL) &
    (bus.ex_rd_addr != 5'd0) &
    (w_hit1 | w_hit2);

  // mutually exclusive selects in priority order
  assign w_sel_rst   = reset;
  assign w_sel_mem   = ~reset & w_mem_stall;
  assign w_sel_br    = ~reset & ~w_mem_stall &
    bus.ex_br_taken;
  assign w_sel_stall = ~reset & ~w_mem_stall &
    ~bus.ex_br_taken &
    ((r_state == LOAD_STALL) | w_load_use);

  always_comb begin
    w_ctrl = C_RUN;
    unique case (1'b1)
      w_sel_rst:   w_ctrl = C_OFF;
      w_sel_mem:   w_ctrl = C_OFF;
      w_sel_br:    w_ctrl = C_FLUSH;
      w_sel_stall: w_ctrl = C_STALL;
      default:     w_ctrl = C_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_rem       <= 2'd0;
      r_wait      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_mem_stall) begin
        if (r_wait != TO_MAX)
          r_wait <= r_wait + WT_W'(1);
        if (r_wait >= TO_MAX - WT_W'(1))
          r_err <= 1'b1;
      end else begin
        r_wait <= '0;
      end

      if (w_sel_br) begin
        r_state <= RUN;
        r_rem   <= 2'd0;
      end else if (w_sel_stall) begin
        if (r_state == LOAD_STALL) begin
          r_rem <= r_rem - 2'd1;
          if (r_rem == 2'd1)
            r_state <= RUN;
        end else if (LOAD_STALL_CYCLES > 1) begin
          r_rem   <= REM_INIT;
          r_state <= LOAD_STALL;
        end
      end

      if (!w_ctrl[6] && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_sel_br && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_en           = w_ctrl[6];
  assign bus.if_id_en        = w_ctrl[5];
  assign bus.if_id_flush     = w_ctrl[4];
  assign bus.id_ex_en        = w_ctrl[3];
  assign bus.id_ex_flush     = w_ctrl[2];
  assign bus.ex_mem_en       = w_ctrl[1];
  assign bus.mem_wb_en       = w_ctrl[0];
  assign bus.state           = r_state;
  assign bus.stall_cnt       = r_stall_cnt;
  assign bus.flush_cnt       = r_flush_cnt;
  assign bus.mem_timeout_err = r_err;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench: two controllers (N=1/TO=2/W=32, N=3/TO=5/W=4)
// on shared stimulus, directed scenarios plus random vs model.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] E_OFF   = 7'b000_0000;
  localparam logic [6:0] E_FLUSH = 7'b111_1111;
  localparam logic [6:0] E_STALL = 7'b000_1111;
  localparam logic [6:0] E_RUN   = 7'b110_1011;

  localparam int MN[2]  = '{1, 3};
  localparam int MTO[2] = '{2, 5};
  localparam int MCW[2] = '{32, 4};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic u1 = 0, u2 = 0, we = 0, br = 0;
  logic mreq = 0, mrdy = 0;
  logic [1:0] wbsel = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(32)) ifa ();
  hazard_stall_ctrl_if #(.CNT_W(4))  ifb ();

  hazard_stall_ctrl #(
    .LOAD_WBSEL(2'b00), .LOAD_STALL_CYCLES(1),
    .MEM_TIMEOUT(2), .CNT_W(32)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

  hazard_stall_ctrl #(
    .LOAD_WBSEL(2'b00), .LOAD_STALL_CYCLES(3),
    .MEM_TIMEOUT(5), .CNT_W(4)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  assign ifa.id_rs1_addr = rs1;
  assign ifa.id_rs2_addr = rs2;
  assign ifa.id_rs1_used = u1;
  assign ifa.id_rs2_used = u2;
  assign ifa.ex_rd_addr  = rd;
  assign ifa.ex_regWEn   = we;
  assign ifa.ex_WBSel    = wbsel;
  assign ifa.ex_br_taken = br;
  assign ifa.mem_req     = mreq;
  assign ifa.mem_ready   = mrdy;
  assign ifb.id_rs1_addr = rs1;
  assign ifb.id_rs2_addr = rs2;
  assign ifb.id_rs1_used = u1;
  assign ifb.id_rs2_used = u2;
  assign ifb.ex_rd_addr  = rd;
  assign ifb.ex_regWEn   = we;
  assign ifb.ex_WBSel    = wbsel;
  assign ifb.ex_br_taken = br;
  assign ifb.mem_req     = mreq;
  assign ifb.mem_ready   = mrdy;

  logic [6:0]  d_ctrl[2];
  logic [31:0] d_stc[2];
  logic [31:0] d_flc[2];
  logic        d_st[2];
  logic        d_err[2];

  assign d_ctrl[0] = {ifa.pc_en, ifa.if_id_en,
    ifa.if_id_flush, ifa.id_ex_en, ifa.id_ex_flush,
    ifa.ex_mem_en, ifa.mem_wb_en};
  assign d_ctrl[1] = {ifb.pc_en, ifb.if_id_en,
    ifb.if_id_flush, ifb.id_ex_en, ifb.id_ex_flush,
    ifb.ex_mem_en, ifb.mem_wb_en};
  assign d_stc[0] = ifa.stall_cnt;
  assign d_stc[1] = {28'd0, ifb.stall_cnt};
  assign d_flc[0] = ifa.flush_cnt;
  assign d_flc[1] = {28'd0, ifb.flush_cnt};
  assign d_st[0]  = ifa.state;
  assign d_st[1]  = ifb.state;
  assign d_err[0] = ifa.mem_timeout_err;
  assign d_err[1] = ifb.mem_timeout_err;

  // reference model: bubbles still owed, wait length, counters
  int     m_left[2];
  int     m_wait[2];
  longint m_stc[2];
  longint m_flc[2];
  bit     m_err[2];

  function automatic bit f_mstall();
    return mreq && !mrdy;
  endfunction

  function automatic bit f_lu();
    return we && wbsel == 2'b00 && rd != 0 &&
      ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  function automatic longint f_sat(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  function automatic logic [6:0] f_ctrl(int k);
    if (reset) return E_OFF;
    if (f_mstall()) return E_OFF;
    if (br) return E_FLUSH;
    if (m_left[k] > 0 || f_lu()) return E_STALL;
    return E_RUN;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_left[k] <= 0;
        m_wait[k] <= 0;
        m_stc[k]  <= 0;
        m_flc[k]  <= 0;
        m_err[k]  <= 0;
      end else if (f_mstall()) begin
        m_wait[k] <= (m_wait[k] + 1 > MTO[k]) ?
          MTO[k] : m_wait[k] + 1;
        if (m_wait[k] + 1 >= MTO[k]) m_err[k] <= 1;
        m_stc[k] <= f_sat(m_stc[k], MCW[k]);
      end else begin
        m_wait[k] <= 0;
        if (br) begin
          m_left[k] <= 0;
          m_flc[k]  <= f_sat(m_flc[k], MCW[k]);
        end else if (m_left[k] > 0) begin
          m_left[k] <= m_left[k] - 1;
          m_stc[k]  <= f_sat(m_stc[k], MCW[k]);
        end else if (f_lu()) begin
          m_left[k] <= MN[k] - 1;
          m_stc[k]  <= f_sat(m_stc[k], MCW[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0;
    we = 0; wbsel = 0; br = 0; mreq = 0; mrdy = 0;
  endtask

  task automatic hazard();
    rd = 5; we = 1; wbsel = 2'b00; rs1 = 5; u1 = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    settle();
    n_vec++;
    if (d_ctrl[0] !== E_OFF) begin
      n_err++;
      $display("FAIL rst_ctrl got %b want %b",
        d_ctrl[0], E_OFF);
    end
    tick();
    reset = 0;
    settle();
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (d_ctrl[k] !== E_RUN || d_st[k] !== 1'b0 ||
          d_stc[k] !== 0 || d_flc[k] !== 0 ||
          d_err[k] !== 1'b0) begin
        n_err++;
        $display("FAIL rst_state k=%0d got %b %b %0d %0d %b",
          k, d_ctrl[k], d_st[k], d_stc[k], d_flc[k],
          d_err[k]);
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    hazard();
    settle();
    n_vec++;
    if (d_ctrl[0] !== E_STALL) begin
      n_err++;
      $display("FAIL lu_bubble got %b want %b",
        d_ctrl[0], E_STALL);
    end
    tick();
    idle();
    settle();
    n_vec++;
    if (d_ctrl[0] !== E_RUN || d_stc[0] !== 1) begin
      n_err++;
      $display("FAIL lu_after got %b/%0d want %b/1",
        d_ctrl[0], d_stc[0], E_RUN);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    hazard();
    rd = 0; rs1 = 0;
    settle();
    n_vec++;
    if (d_ctrl[0] !== E_RUN) begin
      n_err++;
      $display("FAIL nh_rd0 got %b want %b",
        d_ctrl[0], E_RUN);
    end
    tick();
    hazard();
    u1 = 0;
    settle();
    n_vec++;
    if (d_ctrl[1] !== E_RUN) begin
      n_err++;
      $display("FAIL nh_unused got %b want %b",
        d_ctrl[1], E_RUN);
    end
    tick();
    idle();
    settle();
    n_vec++;
    if (d_stc[0] !== 0 || d_stc[1] !== 0) begin
      n_err++;
      $display("FAIL nh_cnt got %0d %0d want 0 0",
        d_stc[0], d_stc[1]);
    end
  endtask

  task automatic test_multi_stall();
    logic [6:0] ec[4] = '{E_STALL, E_STALL, E_STALL, E_RUN};
    logic       es[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    hazard();
    for (int i = 0; i < 4; i++) begin
      settle();
      n_vec++;
      if (d_ctrl[1] !== ec[i] || d_st[1] !== es[i]) begin
        n_err++;
        $display("FAIL ms_cyc%0d got %b/%b want %b/%b",
          i, d_ctrl[1], d_st[1], ec[i], es[i]);
      end
      tick();
      idle();
    end
    settle();
    n_vec++;
    if (d_stc[1] !== 3) begin
      n_err++;
      $display("FAIL ms_cnt got %0d want 3", d_stc[1]);
    end
  endtask

  task automatic test_mem_timeout();
    do_reset();
    mreq = 1;
    mrdy = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_vec++;
      if (d_ctrl[0] !== E_OFF ||
          d_err[0] !== (i >= 2)) begin
        n_err++;
        $display("FAIL mt_wait%0d got %b/%b want %b/%b",
          i, d_ctrl[0], d_err[0], E_OFF, i >= 2);
      end
      tick();
    end
    mrdy = 1;
    settle();
    n_vec++;
    if (d_err[0] !== 1'b1 || d_ctrl[0] !== E_RUN ||
        d_stc[0] !== 3 || d_err[1] !== 1'b0) begin
      n_err++;
      $display("FAIL mt_done got %b/%b/%0d/%b want 1/%b/3/0",
        d_err[0], d_ctrl[0], d_stc[0], d_err[1], E_RUN);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    hazard();
    br = 1;
    settle();
    n_vec++;
    if (d_ctrl[0] !== E_FLUSH || d_ctrl[1] !== E_FLUSH) begin
      n_err++;
      $display("FAIL rd_ctrl got %b %b want %b",
        d_ctrl[0], d_ctrl[1], E_FLUSH);
    end
    tick();
    idle();
    settle();
    n_vec++;
    if (d_flc[0] !== 1 || d_stc[0] !== 0 ||
        d_st[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rd_cnt got %0d/%0d/%b want 1/0/0",
        d_flc[0], d_stc[0], d_st[1]);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    hazard();
    tick();
    idle();
    settle();
    n_vec++;
    if (d_st[1] !== 1'b1) begin
      n_err++;
      $display("FAIL rm_pre got %b want 1", d_st[1]);
    end
    reset = 1;
    tick();
    reset = 0;
    settle();
    n_vec++;
    if (d_st[1] !== 1'b0 || d_stc[1] !== 0 ||
        d_ctrl[1] !== E_RUN) begin
      n_err++;
      $display("FAIL rm_post got %b/%0d/%b want 0/0/%b",
        d_st[1], d_stc[1], d_ctrl[1], E_RUN);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mreq = 1;
    for (int i = 0; i < 20; i++) tick();
    idle();
    br = 1;
    for (int i = 0; i < 18; i++) tick();
    idle();
    settle();
    n_vec++;
    if (d_stc[1] !== 15 || d_stc[0] !== 20 ||
        d_flc[1] !== 15 || d_flc[0] !== 18) begin
      n_err++;
      $display("FAIL sat got %0d %0d %0d %0d want 15 20 15 18",
        d_stc[1], d_stc[0], d_flc[1], d_flc[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 3));
      u1    = 1'($urandom);
      u2    = 1'($urandom);
      we    = ($urandom_range(0, 3) != 0);
      wbsel = ($urandom_range(0, 2) == 0) ?
        2'($urandom) : 2'b00;
      br    = ($urandom_range(0, 7) == 0);
      mreq  = ($urandom_range(0, 3) == 0);
      mrdy  = 1'($urandom);
      settle();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (d_ctrl[k] !== f_ctrl(k) ||
            d_st[k] !== (m_left[k] > 0) ||
            d_stc[k] !== 32'(m_stc[k]) ||
            d_flc[k] !== 32'(m_flc[k]) ||
            d_err[k] !== m_err[k]) begin
          n_err++;
          $display("FAIL rnd%0d k=%0d got %b/%b/%0d/%0d/%b want %b/%b/%0d/%0d/%b",
            i, k, d_ctrl[k], d_st[k], d_stc[k], d_flc[k],
            d_err[k], f_ctrl(k), m_left[k] > 0, m_stc[k],
            m_flc[k], m_err[k]);
        end
      end
      tick();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_multi_stall();
    test_mem_timeout();
    test_redirect();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_err);
    $finish;
  end

endmodule
